// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions: CRC-32 constants,
// MII preamble/SFD nibbles and the RX frame FSM state type.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_e;

endpackage

// File: rtl/mii_rx_frame_if.sv
// Received byte stream towards the RX buffer: data, strobe,
// sof/eof markers and end-of-frame status. master = MAC side.
interface mii_rx_frame_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_crc_ok;
  logic       rx_err;

  modport master (
    output rx_data, rx_valid, rx_sof,
    output rx_eof, rx_crc_ok, rx_err
  );

  modport slave (
    input rx_data, rx_valid, rx_sof,
    input rx_eof, rx_crc_ok, rx_err
  );

endinterface

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 step, one byte per call.
// Ports: crc (current), data (byte, LSB first), next_crc.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next_crc
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i])
        c = (c >> 1) ^ CRC32_POLY;
      else
        c = c >> 1;
    end
    next_crc = c;
  end

endmodule

// File: rtl/mii_rx_frame.sv
// MII RX front end: strips preamble/SFD, packs nibbles into bytes,
// checks FCS and length, streams bytes out on rx, counts frames.
// Ports: rx_clki/rst, phy_rx_dv/phy_rxd in, rx stream, frame counters.
module mii_rx_frame
  import eth_pkg::*;
#(
  parameter int MIN_PRE = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             rx_clki,
  input  logic             rst,
  input  logic             phy_rx_dv,
  input  logic [3:0]       phy_rxd,
  mii_rx_frame_if.master   rx,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_bad_cnt
);

  localparam int BCW = $clog2(MAX_LEN + 2);

  rx_state_e state_q, state_d;

  logic           dv_q;
  logic [3:0]     rxd_q;
  logic [3:0]     pre_cnt;
  logic           hi_q;
  logic [3:0]     lo_nib;
  logic [7:0]     hold;
  logic           hold_vld;
  logic           first_q;
  logic [31:0]    crc_q, crc_nxt;
  logic [BCW-1:0] byte_cnt;

  logic [7:0] data_q;
  logic       valid_q, sof_q, eof_q, ok_q, err_q;

  logic pre_load, pre_inc, start;
  logic nib_lo, nib_hi, fin, over;
  logic crc_good, bad;

  crc32_d8 u_crc (
    .crc      (crc_q),
    .data     ({rxd_q, lo_nib}),
    .next_crc (crc_nxt)
  );

  // byte_cnt only reaches MAX_LEN+1 on an oversize frame
  assign over     = (32'(byte_cnt) == MAX_LEN + 1);
  assign crc_good = (crc_q == CRC32_RESIDUE);
  assign bad      = !crc_good || !hold_vld || hi_q
                 || (32'(byte_cnt) < MIN_LEN)
                 || (32'(byte_cnt) > MAX_LEN);

  always_ff @(posedge rx_clki or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pre_load = 1'b0;
    pre_inc  = 1'b0;
    start    = 1'b0;
    nib_lo   = 1'b0;
    nib_hi   = 1'b0;
    fin      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dv_q) begin
          if (rxd_q == NIB_PRE) begin
            state_d  = PRE;
            pre_load = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!dv_q) begin
          state_d = IDLE;
        end else if (rxd_q == NIB_PRE) begin
          pre_inc = 1'b1;
        end else if (rxd_q == NIB_SFD
                     && 32'(pre_cnt) >= MIN_PRE) begin
          state_d = DATA;
          start   = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (over || !dv_q) begin
          fin     = 1'b1;
          state_d = over ? DROP : IDLE;
        end else if (hi_q) begin
          nib_hi = 1'b1;
        end else begin
          nib_lo = 1'b1;
        end
      end
      DROP: begin
        if (!dv_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_clki or posedge rst) begin
    if (rst) begin
      dv_q          <= 1'b0;
      rxd_q         <= '0;
      pre_cnt       <= '0;
      hi_q          <= 1'b0;
      lo_nib        <= '0;
      hold          <= '0;
      hold_vld      <= 1'b0;
      first_q       <= 1'b0;
      crc_q         <= CRC32_INIT;
      byte_cnt      <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      ok_q          <= 1'b0;
      err_q         <= 1'b0;
      frame_ok_cnt  <= '0;
      frame_bad_cnt <= '0;
    end else begin
      dv_q    <= phy_rx_dv;
      rxd_q   <= phy_rxd;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;

      if (pre_load)
        pre_cnt <= 4'd1;
      if (pre_inc && pre_cnt != 4'hF)
        pre_cnt <= pre_cnt + 4'd1;

      if (start) begin
        hi_q     <= 1'b0;
        byte_cnt <= '0;
        crc_q    <= CRC32_INIT;
        hold_vld <= 1'b0;
        first_q  <= 1'b1;
      end

      if (nib_lo) begin
        lo_nib <= rxd_q;
        hi_q   <= 1'b1;
      end

      // one-byte delay so the last byte can carry eof/status
      if (nib_hi) begin
        hi_q     <= 1'b0;
        crc_q    <= crc_nxt;
        byte_cnt <= byte_cnt + BCW'(1);
        hold     <= {rxd_q, lo_nib};
        hold_vld <= 1'b1;
        if (hold_vld) begin
          valid_q <= 1'b1;
          data_q  <= hold;
          sof_q   <= first_q;
          first_q <= 1'b0;
        end
      end

      if (fin) begin
        hold_vld <= 1'b0;
        if (hold_vld) begin
          valid_q <= 1'b1;
          data_q  <= hold;
          sof_q   <= first_q;
          eof_q   <= 1'b1;
          ok_q    <= crc_good;
          err_q   <= bad;
          first_q <= 1'b0;
        end
        if (bad) begin
          if (~&frame_bad_cnt)
            frame_bad_cnt <= frame_bad_cnt + CNT_W'(1);
        end else begin
          if (~&frame_ok_cnt)
            frame_ok_cnt <= frame_ok_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_sof    = sof_q;
  assign rx.rx_eof    = eof_q;
  assign rx.rx_crc_ok = ok_q;
  assign rx.rx_err    = err_q;

endmodule

// File: tb/tb_mii_rx_frame.sv
// Scoreboard bench for mii_rx_frame: directed MII frames,
// expected byte stream queued at stimulus, checked by a monitor.
`timescale 1ns/1ps
module tb_mii_rx_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phy_rx_dv = 1'b0;
  logic [3:0]  phy_rxd = 4'h0;
  logic [15:0] frame_ok_cnt, frame_bad_cnt;

  mii_rx_frame_if rx_if ();

  mii_rx_frame dut (
    .rx_clki       (clk),
    .rst           (rst),
    .phy_rx_dv     (phy_rx_dv),
    .phy_rxd       (phy_rxd),
    .rx            (rx_if),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_bad_cnt (frame_bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       ok;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e, mon_g;
  logic [7:0] frm[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         exp_ok = 0;
  int         exp_bad = 0;
  bit         mon_en = 1'b1;

  always @(negedge clk) begin
    if (mon_en && rx_if.rx_valid) begin
      mon_g = {rx_if.rx_data, rx_if.rx_sof, rx_if.rx_eof,
               rx_if.rx_crc_ok, rx_if.rx_err};
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected got=%h", mon_g);
      end else begin
        mon_e = sb.pop_front();
        if (mon_g !== mon_e) begin
          n_err++;
          $display("FAIL strobe got d=%h sof%b eof%b ok%b err%b want d=%h sof%b eof%b ok%b err%b",
                   mon_g.d, mon_g.sof, mon_g.eof, mon_g.ok, mon_g.err,
                   mon_e.d, mon_e.sof, mon_e.eof, mon_e.ok, mon_e.err);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] crc_raw(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, frm[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build(input int plen, input int seed);
    logic [31:0] f;
    frm = {};
    for (int i = 0; i < plen; i++)
      frm.push_back(8'((i * 7 + seed * 13) ^ (i >> 3)));
    f = ~crc_raw(plen);
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
    frm.push_back(f[23:16]);
    frm.push_back(f[31:24]);
  endtask

  task automatic push_exp(input int n, input logic ok, input logic err);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.d   = frm[i];
      x.sof = (i == 0);
      x.eof = (i == n - 1);
      x.ok  = (i == n - 1) ? ok : 1'b0;
      x.err = (i == n - 1) ? err : 1'b0;
      sb.push_back(x);
    end
  endtask

  task automatic nib(input logic [3:0] n);
    @(negedge clk);
    phy_rx_dv = 1'b1;
    phy_rxd   = n;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      phy_rx_dv = 1'b0;
      phy_rxd   = 4'h0;
    end
  endtask

  task automatic send_frame(input int nbytes, input bit extra);
    logic [7:0] b;
    repeat (15) nib(4'h5);
    nib(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = frm[i];
      nib(b[3:0]);
      nib(b[7:4]);
    end
    if (extra) nib(4'h3);
    idle(1);
  endtask

  task automatic check(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic settle(input string nm);
    idle(6);
    check({nm, "_ok_cnt"}, int'(frame_ok_cnt), exp_ok);
    check({nm, "_bad_cnt"}, int'(frame_bad_cnt), exp_bad);
    check({nm, "_pending"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_outs_zero(input string nm);
    check({nm, "_data"}, int'(rx_if.rx_data), 0);
    check({nm, "_flags"},
          int'({rx_if.rx_valid, rx_if.rx_sof, rx_if.rx_eof,
                rx_if.rx_crc_ok, rx_if.rx_err}), 0);
    check({nm, "_ok_cnt"}, int'(frame_ok_cnt), 0);
    check({nm, "_bad_cnt"}, int'(frame_bad_cnt), 0);
  endtask

  initial begin
    logic ovf_ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs_zero("reset");

    // good minimum-size frame
    build(60, 1);
    push_exp(64, 1'b1, 1'b0);
    send_frame(64, 1'b0);
    exp_ok++;
    settle("good64");

    // single bit flip in payload
    build(60, 1);
    frm[10] = frm[10] ^ 8'h04;
    push_exp(64, 1'b0, 1'b1);
    send_frame(64, 1'b0);
    exp_bad++;
    settle("crcerr");

    // runt with valid FCS
    build(16, 2);
    push_exp(20, 1'b1, 1'b1);
    send_frame(20, 1'b0);
    exp_bad++;
    settle("runt");

    // broken preamble, 1-cycle gap, then a good frame
    nib(4'h5); nib(4'h5); nib(4'h7); nib(4'h5);
    nib(4'h5); nib(4'hD); nib(4'h1); nib(4'h2);
    idle(1);
    build(60, 3);
    push_exp(64, 1'b1, 1'b0);
    send_frame(64, 1'b0);
    exp_ok++;
    settle("badpre");

    // dribble nibble after a good frame
    build(60, 4);
    push_exp(64, 1'b1, 1'b1);
    send_frame(64, 1'b1);
    exp_bad++;
    settle("dribble");

    // oversize: eof on the 1519th byte, then silence
    build(1596, 5);
    ovf_ok = (crc_raw(1519) == 32'hDEBB20E3);
    push_exp(1519, ovf_ok, 1'b1);
    send_frame(1600, 1'b0);
    exp_bad++;
    settle("oversize");

    // reset in the middle of a frame
    mon_en = 1'b0;
    build(60, 6);
    repeat (15) nib(4'h5);
    nib(4'hD);
    for (int i = 0; i < 10; i++) begin
      nib(frm[i][3:0]);
      nib(frm[i][7:4]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs_zero("midrst");
    phy_rx_dv = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(2);
    exp_ok  = 0;
    exp_bad = 0;
    mon_en  = 1'b1;

    build(60, 7);
    push_exp(64, 1'b1, 1'b0);
    send_frame(64, 1'b0);
    exp_ok++;
    settle("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mii_rx_frame.md
Name: mii_rx_frame

Overview:
- Receive-side MAC front end; sits directly downstream of the Ethernet PHY MII receive pins (phy_rx_dv, phy_rxd0..3, rx_clki) inside m1_soc_top.
- Strips preamble/SFD, assembles nibbles into bytes, checks FCS (CRC-32) and frame length.
- Emits a byte stream with sof/eof markers and a frame status to the downstream RX buffer / AHB bridge.
- Keeps saturating good/bad frame counters.

Parameters:
- MIN_PRE, 2: minimum count of 0x5 nibbles required before the SFD nibble 0xD.
- MIN_LEN, 64: minimum frame length in bytes, DA through FCS inclusive.
- MAX_LEN, 1518: maximum frame length in bytes, DA through FCS inclusive.
- CNT_W, 16: width of the frame counters.

Ports:
- rx_clki  in  1  PHY receive clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- phy_rx_dv  in  1  MII receive data valid.
- phy_rxd  in  4  MII receive nibble, {rxd3,rxd2,rxd1,rxd0}.
- rx_data  out  8  received byte; FCS bytes included.
- rx_valid  out  1  one-cycle strobe; rx_data is valid.
- rx_sof  out  1  qualifies rx_valid; first byte (DA[0]).
- rx_eof  out  1  qualifies rx_valid; last byte of the frame.
- rx_crc_ok  out  1  valid with rx_eof; CRC residue is correct.
- rx_err  out  1  valid with rx_eof; frame is bad for any reason.
- frame_ok_cnt  out  CNT_W  count of good frames, saturating.
- frame_bad_cnt  out  CNT_W  count of bad frames, saturating.

Behaviour:
- Input stage: phy_rx_dv and phy_rxd are registered once on the rising edge of rx_clki. All logic below works on the registered copies (dv_q, rxd_q).
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-frame abandons the frame; no eof is emitted and no counter changes.
- Nibble order: low nibble first; byte = {second nibble, first nibble}.
- FSM states:
  - IDLE: on dv_q=1 go to PRE, with pre_cnt=1 if rxd_q=0x5, else go to DROP.
  - PRE:
    - rxd_q=0x5: pre_cnt increments, saturating at 15.
    - rxd_q=0xD with pre_cnt>=MIN_PRE: go to DATA; the next nibble is the low nibble of DA[0].
    - Any other nibble: go to DROP.
    - dv_q=0: go to IDLE. Nothing is emitted and no counter changes.
  - DATA:
    - Low and high nibbles alternate. On each high nibble the byte is complete: the CRC is updated, byte_cnt increments, and the byte enters a one-byte holding register.
    - The previously held byte, if any, is emitted (rx_valid=1) in the cycle after the new byte completes. rx_sof=1 on the first byte emitted.
    - dv_q=0 seen: the held byte is emitted in the next cycle with rx_eof=1, then the FSM goes to IDLE.
    - byte_cnt reaching MAX_LEN+1: the held byte is emitted immediately with rx_eof=1 and rx_err=1, then the FSM goes to DROP.
  - DROP: ignores input until dv_q=0, then goes to IDLE. A new frame needs dv_q low for at least 1 cycle.
- CRC: IEEE 802.3 CRC-32, reflected, init 0xFFFFFFFF, computed over all bytes including the FCS. rx_crc_ok=1 when the register equals the residue 0xDEBB20E3 (un-inverted).
- rx_err at eof is the OR of:
  - !rx_crc_ok
  - byte_cnt<MIN_LEN
  - byte_cnt>MAX_LEN
  - dribble: dv_q fell after a low nibble; the partial nibble is discarded.
- A frame with zero complete bytes emits nothing and counts as bad.
- Counters: at eof, increment frame_ok_cnt if !rx_err, else frame_bad_cnt. Each counter saturates at all-ones. Aborts from preamble errors are not counted.
- Outputs between strobes: rx_sof, rx_eof, rx_crc_ok and rx_err are 0 whenever rx_valid=0. rx_data holds its last value.
- Throughput: at most one byte every 2 cycles; the downstream stage has no backpressure.

Decomposition:
- Shared package eth_pkg:
  - CRC32_POLY (0xEDB88320 reflected), CRC32_INIT, CRC32_RESIDUE.
  - NIB_PRE=4'h5, NIB_SFD=4'hD.
  - FSM state enum {IDLE, PRE, DATA, DROP}.
- One sub-module, crc32_d8: combinational 8-bit-per-step CRC update, next_crc = f(crc, byte). It is reused later by the TX MAC.

Test Plan:
- 7x 0x55 + 0xD5, then 60-byte payload + correct FCS (64 bytes total) -> 64 rx_valid strobes; sof on byte 0; eof on byte 63 with crc_ok=1, err=0; frame_ok_cnt=1.
- Same frame with one payload bit flipped -> eof with crc_ok=0, err=1; frame_bad_cnt=1, frame_ok_cnt unchanged.
- 20-byte frame with valid FCS -> eof with crc_ok=1, err=1 (runt); frame_bad_cnt increments.
- Preamble 0x5,0x5,0x7,... -> no rx_valid at all, counters unchanged. Next frame after a 1-cycle dv gap is received normally.
- Good 64-byte frame plus one extra nibble before dv falls -> eof on byte 63 (the FCS-correct, extra-nibble-free last byte) with err=1 (dribble).
- 1600-byte frame -> eof with err=1 on byte 1518 (the 1519th); no strobes afterwards until dv falls.
- Reset mid-frame -> all outputs 0 the same cycle; counters 0.
